serial_subtractor: RTL and testbench

//   Bit-serial subtractor: the inverse operation of the combinational full adder.

---
 rtl/serial_subtractor_pkg.sv | 24 ++
 rtl/serial_subtractor_full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and a
// constant-width helper used to size the bit counter.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Ceiling log2; clog2(1) = 0 so a 1-bit operand still gets a 1-bit counter
    // once the caller adds its spare bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: x - y - bin -> difference bit d and borrow out.
// Purely combinational; peer of the full adder with the same port style.
module full_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = x_i ^ y_i ^ bin_i;
    assign bout_o = (~x_i & y_i) | (~x_i & bin_i) | (y_i & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// A start in IDLE or DONE latches the operands; WIDTH SHIFT cycles later the
// result appears for one DONE cycle and is held on diff/bout afterwards.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; last result held on diff/bout
// ST_SHIFT | one full-subtractor bit per cycle, busy high
// ST_DONE  | one cycle, done high; start here chains the next operation
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // One spare bit keeps WIDTH=1 legal (counter width never reaches zero).
    localparam int CNT_W = clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic fs_d;
    logic fs_bo;

    full_subtractor u_fs (
        .x_i   (ra_q[0]),
        .y_i   (rb_q[0]),
        .bin_i (brw_q),
        .d_o   (fs_d),
        .bout_o(fs_bo)
    );

    // Next-state and datapath: busy/done are computed from the next state so
    // the outputs come straight off flops.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    ra_d    = a;
                    rb_d    = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    brw_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                ra_d             = ra_q >> 1;
                rb_d             = rb_q >> 1;
                // Shift-then-insert form works for WIDTH=1 without a null slice.
                acc_d            = acc_q >> 1;
                acc_d[WIDTH-1]   = fs_d;
                brw_d            = fs_bo;
                cnt_d            = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    diff_d  = acc_d;
                    bout_d  = fs_bo;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8 and WIDTH=1, with an arithmetic
// reference model checked every cycle plus directed literal expectations.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: remaining-cycle counter plus the arithmetic result.
    int         m8_rem = 0;
    logic       m8_busy = 0, m8_done = 0, m8_bout = 0, p8_bout = 0;
    logic [7:0] m8_diff = 0, p8_diff = 0;
    int         m1_rem = 0;
    logic       m1_busy = 0, m1_done = 0, m1_bout = 0, p1_bout = 0;
    logic [0:0] m1_diff = 0, p1_diff = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_rem = 0; m8_busy = 0; m8_done = 0; m8_diff = 0; m8_bout = 0;
            m1_rem = 0; m1_busy = 0; m1_done = 0; m1_diff = 0; m1_bout = 0;
        end else begin
            m8_done = 0;
            if (m8_rem > 0) begin
                m8_rem--;
                if (m8_rem == 0) begin
                    m8_done = 1; m8_diff = p8_diff; m8_bout = p8_bout;
                end
            end else if (start8) begin
                m8_rem = 8; p8_diff = a8 - b8; p8_bout = (a8 < b8);
            end
            m8_busy = (m8_rem > 0);

            m1_done = 0;
            if (m1_rem > 0) begin
                m1_rem--;
                if (m1_rem == 0) begin
                    m1_done = 1; m1_diff = p1_diff; m1_bout = p1_bout;
                end
            end else if (start1) begin
                m1_rem = 1; p1_diff = a1 - b1; p1_bout = (a1 < b1);
            end
            m1_busy = (m1_rem > 0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy8", 32'(busy8), 32'(m8_busy));
        chk("done8", 32'(done8), 32'(m8_done));
        chk("diff8", 32'(diff8), 32'(m8_diff));
        chk("bout8", 32'(bout8), 32'(m8_bout));
        chk("busy1", 32'(busy1), 32'(m1_busy));
        chk("done1", 32'(done1), 32'(m1_done));
        chk("diff1", 32'(diff1), 32'(m1_diff));
        chk("bout1", 32'(bout1), 32'(m1_bout));
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cycles);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        busy_cycles = busy8 ? 1 : 0;
        while (!done8 && lat < 30) begin
            @(negedge clk);
            lat++;
            if (busy8) busy_cycles++;
        end
        if (!done8) chk("timeout8", 0, 1);
    endtask

    task automatic run1(input logic a, input logic b, output int lat);
        @(negedge clk);
        a1 = a; b1 = b; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!done1) chk("timeout1", 0, 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[6] = '{
        '{8'd5,   8'd3,   8'd2,   1'b0},
        '{8'd3,   8'd5,   8'hFE,  1'b1},
        '{8'd0,   8'd1,   8'hFF,  1'b1},
        '{8'hA5,  8'hA5,  8'h00,  1'b0},
        '{8'h00,  8'hFF,  8'h01,  1'b1},
        '{8'hFF,  8'h00,  8'hFF,  1'b0}
    };

    initial begin
        int lat, bc, dones;
        logic [7:0] seen;
        logic [7:0] ra, rb;
        logic [1:0] ab;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_diff", 32'(diff8), 0);
        chk("rst_bout", 32'(bout8), 0);
        rst_n = 1'b1;

        // Directed vectors: latency, busy length and literal results.
        foreach (vecs[i]) begin
            run8(vecs[i].a, vecs[i].b, lat, bc);
            chk("lat8", 32'(lat), 9);
            chk("busycnt8", 32'(bc), 8);
            chk("vec_diff", 32'(diff8), 32'(vecs[i].d));
            chk("vec_bout", 32'(bout8), 32'(vecs[i].bo));
        end

        // Start mid-SHIFT with new operands is ignored.
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd30; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'd1; b8 = 8'd200; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0; seen = '0;
        repeat (15) begin
            @(negedge clk);
            if (done8) begin dones++; seen = diff8; end
        end
        chk("midshift_dones", 32'(dones), 1);
        chk("midshift_diff", 32'(seen), 32'd70);

        // Back-to-back: start held through the DONE cycle.
        run8(8'd7, 8'd2, lat, bc);
        chk("b2b_first", 32'(diff8), 32'd5);
        a8 = 8'd10; b8 = 8'd4; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b_busy", 32'(busy8), 1);
        lat = 1;
        while (!done8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_lat", 32'(lat), 9);
        chk("b2b_diff", 32'(diff8), 32'd6);

        // Reset during the 4th SHIFT cycle.
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd20; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy8), 0);
        chk("abort_done", 32'(done8), 0);
        chk("abort_diff", 32'(diff8), 0);
        chk("abort_bout", 32'(bout8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) dones++;
        end
        chk("abort_nodone", 32'(dones), 0);
        run8(8'd200, 8'd55, lat, bc);
        chk("after_abort_lat", 32'(lat), 9);
        chk("after_abort_diff", 32'(diff8), 32'd145);

        // WIDTH=1 exhaustive.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            run1(ab[1], ab[0], lat);
            chk("w1_lat", 32'(lat), 2);
            chk("w1_diff", 32'(diff1), 32'(ab[1] ^ ab[0]));
            chk("w1_bout", 32'(bout1), 32'(~ab[1] & ab[0]));
        end

        // Random pairs against plain arithmetic.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run8(ra, rb, lat, bc);
            chk("rand_diff", 32'(diff8), 32'(8'(ra - rb)));
            chk("rand_bout", 32'(bout8), 32'(ra < rb));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
